maze_mem_arbiter: RTL and testbench

- Shares the single-port maze cell memory between N_REQ requesters: port 0 maze loader, port 1 solver controller (visited-mark RD/WR), port 2 path-replay reader.
- Round-robin arbitration with a per-access grant/response handshake.
- Sits between the requesters and the synchronous maze RAM; memory read latency is one cycle.

---
 rtl/maze_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_maze_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port maze cell RAM between N_REQ requesters.
// Define MAZE_ARB_LOCK_EN to let a requester hold the RAM across a locked burst.
module maze_mem_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy
);

  localparam int unsigned OwnW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IdxW = OwnW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q;
  logic [OwnW-1:0]     owner_q;
  logic [OwnW-1:0]     rr_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    rvalid_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                busy_q;

  logic [OwnW-1:0]     next_owner;
  logic [OwnW-1:0]     search_start;
  logic [OwnW-1:0]     winner;
  logic [OwnW-1:0]     cand;
  logic [IdxW-1:0]     idx;
  logic                found;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef MAZE_ARB_LOCK_EN
  logic                lock_q;
  logic                lock_hold;
`else
  logic                unused_req_lock;
  assign unused_req_lock = ^req_lock;
`endif

  function automatic logic [N_REQ-1:0] one_hot(input logic [OwnW-1:0] sel);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  always_comb begin
    next_owner = (owner_q == OwnW'(N_REQ - 1)) ? '0 : owner_q + OwnW'(1);
  end

  // Winner: first requesting port at or above the search start, wrapping.
  always_comb begin
    search_start = rr_q;
`ifdef MAZE_ARB_LOCK_EN
    lock_hold = lock_q && req[owner_q] && req_lock[owner_q];
    if (lock_q) begin
      search_start = next_owner;
    end
`endif
    winner = search_start;
    found  = 1'b0;
    idx    = '0;
    cand   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = {1'b0, search_start} + IdxW'(i);
      if (idx >= IdxW'(N_REQ)) begin
        idx = idx - IdxW'(N_REQ);
      end
      cand = idx[OwnW-1:0];
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
`ifdef MAZE_ARB_LOCK_EN
    if (lock_hold) begin
      winner = owner_q;
      found  = 1'b1;
    end
`endif
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (OwnW'(i) == winner) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_q        <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MAZE_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef MAZE_ARB_LOCK_EN
          // Lock released: step the pointer past the previous owner.
          if (lock_q && !lock_hold) begin
            lock_q <= 1'b0;
            rr_q   <= next_owner;
          end
`endif
          if (found) begin
            state_q     <= StIssue;
            owner_q     <= winner;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            gnt_q       <= one_hot(winner);
            mem_en_q    <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        StIssue: begin
`ifdef MAZE_ARB_LOCK_EN
          if (req_lock[owner_q]) begin
            lock_q <= 1'b1;
          end else begin
            lock_q <= 1'b0;
            rr_q   <= next_owner;
          end
`else
          rr_q <= next_owner;
`endif
          if (mem_we_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= StResp;
            rvalid_q <= one_hot(owner_q);
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  // RAM output is already registered, so read data is forwarded during the response cycle.
  assign rdata     = (|rvalid_q) ? mem_rdata : '0;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Scoreboard bench for maze_mem_arbiter: per-port requester queues, a RAM model and grant order.
module tb_maze_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic          wdata;
    logic          lock;
  } cmd_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;

  maze_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_lock  (req_lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t cmd_q[N][$];
  cmd_t cur[N];
  logic exp_rd[N][$];
  int   exp_gnt[$];
  logic ram[256];
  logic ref_mem[256];

  logic [N-1:0]  g_hist[16];
  logic [N-1:0]  r_hist[16];
  logic          b_hist[16];
  logic          d_hist[16];
  logic          en_hist[16];
  logic          we_hist[16];
  logic          wd_hist[16];
  logic [AW-1:0] a_hist[16];

  function automatic logic pat(input logic [7:0] a);
    return ^(a & 8'hA3);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < N; p++) s += exp_rd[p].size() + cmd_q[p].size();
    return s;
  endfunction

  function automatic int low_bit(input logic [N-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push_cmd(input int p, input logic we, input logic [7:0] a, input logic wd,
                          input logic lk);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd; c.lock = lk;
    cmd_q[p].push_back(c);
  endtask

  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      g_hist[k] = gnt; r_hist[k] = rvalid; b_hist[k] = busy; d_hist[k] = rdata;
      en_hist[k] = mem_en; we_hist[k] = mem_we; wd_hist[k] = mem_wdata; a_hist[k] = mem_addr;
    end
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (n < 100 && !(req == '0 && !busy && exp_gnt.size() == 0 && pending() == 0)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, (n >= 100) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_gnt(input int p, input string tag);
    int n = 0;
    while (n < 50 && !gnt[p]) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_gnt_timeout"}, (n >= 50) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_gnt"}, gnt, 0);
    check_eq({tag, "_rvalid"}, rvalid, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_mem_en"}, mem_en, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // RAM model: one-cycle registered read.
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = pat(8'(i));
      ref_mem[i] = pat(8'(i));
    end
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        else mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Requesters: raise the next queued command after an edge, drop on the grant cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (rst_n && !req[p] && cmd_q[p].size() > 0) begin
          cur[p]               = cmd_q[p].pop_front();
          req_we[p]            = cur[p].we;
          req_addr[p*AW +: AW] = cur[p].addr;
          req_wdata[p]         = cur[p].wdata;
          req_lock[p]          = cur[p].lock;
          req[p]               = 1'b1;
        end
      end
    end
  end

  // Monitor and scoreboard.
  initial begin
    int gp;
    int rp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (gnt != '0) begin
          gp = low_bit(gnt);
          check_eq("gnt_onehot", $countones(gnt), 1);
          if (exp_gnt.size() == 0) check_eq("gnt_unexpected", gnt, 0);
          else check_eq("gnt_port", gp, exp_gnt.pop_front());
          check_eq($sformatf("mem_en_p%0d", gp), mem_en, 1);
          check_eq($sformatf("busy_gnt_p%0d", gp), busy, 1);
          check_eq($sformatf("mem_addr_p%0d", gp), mem_addr, cur[gp].addr);
          check_eq($sformatf("mem_we_p%0d", gp), mem_we, cur[gp].we);
          if (cur[gp].we) begin
            check_eq($sformatf("mem_wdata_p%0d", gp), mem_wdata, cur[gp].wdata);
            ref_mem[cur[gp].addr] = cur[gp].wdata;
          end else begin
            exp_rd[gp].push_back(ref_mem[cur[gp].addr]);
          end
          req[gp]      = 1'b0;
          req_lock[gp] = 1'b0;
        end else begin
          check_eq("mem_en_idle", mem_en, 0);
        end
        if (rvalid != '0) begin
          rp = low_bit(rvalid);
          check_eq("rvalid_onehot", $countones(rvalid), 1);
          if (exp_rd[rp].size() == 0) check_eq("rvalid_unexpected", rvalid, 0);
          else check_eq($sformatf("rdata_p%0d", rp), rdata, exp_rd[rp].pop_front());
          check_eq("busy_resp", busy, 1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #10;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: three reads together straight out of reset.
    push_cmd(0, 1'b0, 8'h10, 1'b0, 1'b0);
    push_cmd(1, 1'b0, 8'h11, 1'b0, 1'b0);
    push_cmd(2, 1'b0, 8'h12, 1'b0, 1'b0);
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    @(posedge clk);
    watch(10);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("cont_gnt_c%0d", k), g_hist[k],
               (k == 1) ? 3'b001 : (k == 4) ? 3'b010 : (k == 7) ? 3'b100 : 3'b000);
      check_eq($sformatf("cont_rvalid_c%0d", k), r_hist[k],
               (k == 2) ? 3'b001 : (k == 5) ? 3'b010 : (k == 8) ? 3'b100 : 3'b000);
    end
    wait_quiet("contention");

    // Single read on port 1.
    push_cmd(1, 1'b0, 8'h23, 1'b0, 1'b0);
    exp_gnt.push_back(1);
    @(posedge clk);
    watch(4);
    check_eq("rd_gnt_c0", g_hist[0], 3'b000);
    check_eq("rd_gnt_c1", g_hist[1], 3'b010);
    check_eq("rd_mem_en_c1", en_hist[1], 1);
    check_eq("rd_mem_addr_c1", a_hist[1], 8'h23);
    check_eq("rd_mem_we_c1", we_hist[1], 0);
    check_eq("rd_rvalid_c2", r_hist[2], 3'b010);
    check_eq("rd_rdata_c2", d_hist[2], 1);
    check_eq("rd_busy_c2", b_hist[2], 1);
    check_eq("rd_busy_c3", b_hist[3], 0);
    wait_quiet("single_read");

    // Single write on port 0.
    push_cmd(0, 1'b1, 8'hFF, 1'b1, 1'b0);
    exp_gnt.push_back(0);
    @(posedge clk);
    watch(4);
    check_eq("wr_gnt_c1", g_hist[1], 3'b001);
    check_eq("wr_mem_we_c1", we_hist[1], 1);
    check_eq("wr_mem_wdata_c1", wd_hist[1], 1);
    check_eq("wr_busy_c1", b_hist[1], 1);
    check_eq("wr_busy_c2", b_hist[2], 0);
    check_eq("wr_rvalid_c2", r_hist[2], 3'b000);
    check_eq("wr_mem_en_c2", en_hist[2], 0);
    wait_quiet("single_write");

    // Read the written cell back through port 2, leaving the pointer at 0.
    push_cmd(2, 1'b0, 8'hFF, 1'b0, 1'b0);
    exp_gnt.push_back(2);
    wait_quiet("readback");

    // Rotation: 0 beats 2; port 2 withdraws; then 1 beats 0.
    push_cmd(0, 1'b1, 8'h60, 1'b1, 1'b0);
    push_cmd(2, 1'b1, 8'h61, 1'b1, 1'b0);
    exp_gnt.push_back(0);
    wait_gnt(0, "rot");
    req[2] = 1'b0;
    push_cmd(1, 1'b1, 8'h62, 1'b1, 1'b0);
    push_cmd(0, 1'b1, 8'h63, 1'b1, 1'b0);
    exp_gnt.push_back(1); exp_gnt.push_back(0);
    wait_quiet("rotation");

    // Reset during the response cycle of a port 1 read.
    push_cmd(1, 1'b0, 8'h30, 1'b0, 1'b0);
    exp_gnt.push_back(1);
    wait_gnt(1, "rst");
    @(posedge clk);
    #2;
    check_eq("rst_pre_rvalid", rvalid, 3'b010);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    exp_rd[1].delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_hold_rvalid", rvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    push_cmd(2, 1'b0, 8'h31, 1'b0, 1'b0);
    push_cmd(1, 1'b0, 8'h33, 1'b0, 1'b0);
    exp_gnt.push_back(1); exp_gnt.push_back(2);
    wait_quiet("post_reset");

    // Locked burst from port 0 against port 1.
    for (int i = 0; i < 4; i++) push_cmd(0, 1'b1, 8'(8'h40 + i), 1'(i), 1'b1);
    push_cmd(1, 1'b1, 8'h50, 1'b1, 1'b0);
    push_cmd(1, 1'b1, 8'h51, 1'b1, 1'b0);
`ifdef MAZE_ARB_LOCK_EN
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(0);
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(1);
`else
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0);
    exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(0);
`endif
    wait_quiet("lock");

    // Read back one locked write to confirm data landed.
    push_cmd(2, 1'b0, 8'h41, 1'b0, 1'b0);
    exp_gnt.push_back(2);
    wait_quiet("lock_readback");

    check_eq("exp_gnt_left", exp_gnt.size(), 0);
    check_eq("pending_left", pending(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
